pid_angle_control: RTL and testbench

//  Closed-loop balance controller for the angle/gyro sensor path.
//  - Computes a signed PID correction from the measured tilt angle and angular rate.
//  - Error is against a fixed target angle.
//  - The registered, saturated result drives the downstream motor/PWM command stage.

---
 rtl/pid_pkg.sv | 37 +++
 rtl/pid_sat.sv | 36 +++
 rtl/pid_angle_control.sv | 125 ++++++++++++
 tb/tb_pid_angle_control.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// ---------------------------------------------------------------------------
// pid_pkg
// Shared widths, output limits and helper types for the balance PID
// controller (pid_angle_control) and its saturator (pid_sat).
//   ANGLE_W  width of the angle/gyro sensor samples
//   OUT_W    width of the control output
//   ERR_W    width of the angle error (setpoint minus measured angle)
//   ACC_W    width of the optional integral accumulator
//   SUM_W    working width of the p/d/i sum; wide enough that it never wraps
// ---------------------------------------------------------------------------
package pid_pkg;

   localparam int ANGLE_W = 9;
   localparam int OUT_W   = 17;
   localparam int ERR_W   = 11;
   localparam int ACC_W   = 16;
   localparam int SUM_W   = 26;

   localparam int OUT_MAX = 65535;
   localparam int OUT_MIN = -65536;

   typedef logic signed [OUT_W-1:0] out_t;
   typedef logic signed [SUM_W-1:0] sum_t;

   // Clamp a full-width sum into the output range instead of letting it wrap.
   function automatic out_t sat_out(input sum_t value);
      out_t result;
      result = value[OUT_W-1:0];
      if (value > SUM_W'(OUT_MAX)) begin
         result = OUT_W'(OUT_MAX);
      end else if (value < SUM_W'(OUT_MIN)) begin
         result = OUT_W'(OUT_MIN);
      end
      return result;
   endfunction

endpackage

// File: rtl/pid_sat.sv
// ---------------------------------------------------------------------------
// pid_sat
// Combinational signed saturator. Clamps a signed IN_W value to the inclusive
// range [MIN_VAL, MAX_VAL] and returns it as a signed OUT_W value. The limits
// default to the full OUT_W range, but narrower limits are allowed (the
// integral clamp uses +/-I_LIMIT).
// Ports:
//   value    in   IN_W   signed value to clamp
//   clamped  out  OUT_W  signed clamped result
// ---------------------------------------------------------------------------
module pid_sat #(
   parameter int IN_W    = 26,
   parameter int OUT_W   = 17,
   parameter int MAX_VAL = (2 ** (OUT_W - 1)) - 1,
   parameter int MIN_VAL = -(2 ** (OUT_W - 1))
) (
   input  logic signed [IN_W-1:0]  value,
   output logic signed [OUT_W-1:0] clamped
);

   // Limits expressed in the input width so the compares are purely signed.
   localparam logic signed [IN_W-1:0]  MAX_IN  = IN_W'(MAX_VAL);
   localparam logic signed [IN_W-1:0]  MIN_IN  = IN_W'(MIN_VAL);
   localparam logic signed [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_VAL);
   localparam logic signed [OUT_W-1:0] MIN_OUT = OUT_W'(MIN_VAL);

   always_comb begin
      clamped = value[OUT_W-1:0];
      if (value > MAX_IN) begin
         clamped = MAX_OUT;
      end else if (value < MIN_IN) begin
         clamped = MIN_OUT;
      end
   end

endmodule

// File: rtl/pid_angle_control.sv
// ---------------------------------------------------------------------------
// pid_angle_control
// Closed-loop balance controller. Two-stage pipeline: stage 1 registers the
// measured tilt angle and angular rate; stage 2 computes
//   KP*(TARGET_ANGLE - angle) - KD*gyro (+ KI*acc)
// and registers the result saturated to 17 bits for the motor/PWM stage.
// A new result is produced every cycle with two cycles of latency.
//
// Optional build macro PID_INTEGRAL_EN adds an integral accumulator, clamped
// to +/-I_LIMIT, whose pre-update value feeds the stage-2 sum. Without the
// macro the controller is pure PD and KI/I_LIMIT have no effect.
//
// Ports:
//   Clk           in   1   clock, rising edge
//   Rst           in   1   asynchronous active-high reset
//   CurrentAngle  in   9   signed measured angle
//   CurrentGyro   in   9   signed angular rate
//   ResultOut     out  17  signed saturated control output
// ---------------------------------------------------------------------------
module pid_angle_control
   import pid_pkg::*;
#(
   parameter logic signed [9:0] TARGET_ANGLE = 10'sd90,
   parameter logic [7:0]        KP           = 8'd20,
   parameter logic [7:0]        KD           = 8'd4,
   parameter logic [7:0]        KI           = 8'd1,
   parameter int                I_LIMIT      = 4096
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic [ANGLE_W-1:0] CurrentAngle,
   input  logic [ANGLE_W-1:0] CurrentGyro,
   output logic [OUT_W-1:0]   ResultOut
);

   // Gains are unsigned; a zero sign bit is prepended before widening so the
   // multiplies stay signed.
   localparam sum_t KP_S = SUM_W'($signed({1'b0, KP}));
   localparam sum_t KD_S = SUM_W'($signed({1'b0, KD}));

   logic signed [ANGLE_W-1:0] ang_q;
   logic signed [ANGLE_W-1:0] gyr_q;
   logic signed [ERR_W-1:0]   err;
   sum_t                      p_term;
   sum_t                      d_term;
   sum_t                      i_term;
   sum_t                      sum;
   out_t                      sum_sat;

   // Stage 1: capture the raw sensor samples.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         ang_q <= '0;
         gyr_q <= '0;
      end else begin
         ang_q <= $signed(CurrentAngle);
         gyr_q <= $signed(CurrentGyro);
      end
   end

   // Error and P/D products; ERR_W and SUM_W are wide enough that none of
   // these can overflow for any 9-bit input and 8-bit gain.
   assign err    = ERR_W'(TARGET_ANGLE) - ERR_W'(ang_q);
   assign p_term = SUM_W'(err) * KP_S;
   assign d_term = SUM_W'(gyr_q) * KD_S;

`ifdef PID_INTEGRAL_EN
   localparam int   ACC_SUM_W = ACC_W + 1;
   localparam sum_t KI_S      = SUM_W'($signed({1'b0, KI}));

   logic signed [ACC_W-1:0]     acc;
   logic signed [ACC_SUM_W-1:0] acc_sum;
   logic signed [ACC_W-1:0]     acc_next;

   // One extra bit so acc + err cannot wrap before the clamp sees it.
   assign acc_sum = ACC_SUM_W'(acc) + ACC_SUM_W'(err);

   pid_sat #(
      .IN_W   (ACC_SUM_W),
      .OUT_W  (ACC_W),
      .MAX_VAL(I_LIMIT),
      .MIN_VAL(-I_LIMIT)
   ) u_acc_sat (
      .value  (acc_sum),
      .clamped(acc_next)
   );

   // Integrator: updated every cycle with the clamped running sum.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         acc <= '0;
      end else begin
         acc <= acc_next;
      end
   end

   // The sum uses the accumulator value from before this cycle's update.
   assign i_term = SUM_W'(acc) * KI_S;
`else
   logic unused_cfg;

   assign i_term     = '0;
   assign unused_cfg = ^{KI, I_LIMIT[0]};
`endif

   assign sum = p_term - d_term + i_term;

   pid_sat #(
      .IN_W (SUM_W),
      .OUT_W(OUT_W)
   ) u_out_sat (
      .value  (sum),
      .clamped(sum_sat)
   );

   // Stage 2: register the saturated control output.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         ResultOut <= '0;
      end else begin
         ResultOut <= sum_sat;
      end
   end

endmodule

// File: tb/tb_pid_angle_control.sv
// ---------------------------------------------------------------------------
// tb_pid_angle_control
// Drives two controllers (default gains and KP=KD=255) with the same angle and
// gyro samples. Each issued sample has its expected outputs computed by an
// arithmetic model of the control law and queued with the cycle on which it
// should appear; a separate monitor compares the outputs against the queue.
// ---------------------------------------------------------------------------
module tb_pid_angle_control;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic [8:0]  CurrentAngle = '0;
   logic [8:0]  CurrentGyro  = '0;
   logic [16:0] res_def;
   logic [16:0] res_hi;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int due;
      int exp_def;
      int exp_hi;
      int angle;
      int gyro;
   } exp_t;

   exp_t sb[$];

   // Model state for the integrator of each controller (index 0 default, 1 high gain).
   int acc_m[2];
   int prev_err[2];

   always #5 Clk = ~Clk;

   pid_angle_control dut_def (
      .Clk         (Clk),
      .Rst         (Rst),
      .CurrentAngle(CurrentAngle),
      .CurrentGyro (CurrentGyro),
      .ResultOut   (res_def)
   );

   pid_angle_control #(
      .KP(8'd255),
      .KD(8'd255)
   ) dut_hi (
      .Clk         (Clk),
      .Rst         (Rst),
      .CurrentAngle(CurrentAngle),
      .CurrentGyro (CurrentGyro),
      .ResultOut   (res_hi)
   );

   function automatic int clampInt(int v, int lo, int hi);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   // Control law: KP*(90 - angle) - KD*gyro (+ KI*acc), clamped to 17 bits.
   function automatic int predict(int idx, int kp, int kd, int angle, int gyro);
      int s;
      s = kp * (90 - angle) - kd * gyro;
`ifdef PID_INTEGRAL_EN
      acc_m[idx]    = clampInt(acc_m[idx] + prev_err[idx], -4096, 4096);
      s             = s + acc_m[idx];
      prev_err[idx] = 90 - angle;
`endif
      return clampInt(s, -65536, 65535);
   endfunction

   // After reset the registered angle is 0, so the first integrator step adds 90.
   task automatic resetModel();
      for (int i = 0; i < 2; i++) begin
         acc_m[i]    = 0;
         prev_err[i] = 90;
      end
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drive one sample, queue its expected outputs, advance one cycle.
   task automatic applyStimulus(input int angle, input int gyro);
      exp_t e;
      CurrentAngle = 9'(angle);
      CurrentGyro  = 9'(gyro);
      e.due     = cyc + 2;
      e.exp_def = predict(0, 20, 4, angle, gyro);
      e.exp_hi  = predict(1, 255, 255, angle, gyro);
      e.angle   = angle;
      e.gyro    = gyro;
      sb.push_back(e);
      @(negedge Clk);
   endtask

   // Monitor: compare every output that is due on this edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge Clk);
         #1;
         if (Rst) begin
            cyc = 0;
         end else begin
            cyc++;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
               e = sb.pop_front();
               checkOutput($sformatf("def a=%0d g=%0d", e.angle, e.gyro),
                           int'($signed(res_def)), e.exp_def);
               checkOutput($sformatf("hi a=%0d g=%0d", e.angle, e.gyro),
                           int'($signed(res_hi)), e.exp_hi);
            end
         end
      end
   end

   initial begin
      int a;
      int g;
      int drain;

      resetModel();
      // Reset held with arbitrary inputs; outputs must be 0 mid-cycle.
      CurrentAngle = 9'h0AB;
      CurrentGyro  = 9'h155;
      repeat (3) @(posedge Clk);
      #3;
      checkOutput("reset_def", int'($signed(res_def)), 0);
      checkOutput("reset_hi", int'($signed(res_hi)), 0);

      @(negedge Clk);
      Rst = 1'b0;

      // Directed holds, each long enough to see the 2-cycle step response.
      repeat (4) applyStimulus(100, 30);
      repeat (4) applyStimulus(80, -30);
      repeat (4) applyStimulus(110, 20);
      repeat (4) applyStimulus(-256, -256);
      repeat (4) applyStimulus(255, 255);
      repeat (4) applyStimulus(90, 0);

      // Randomized samples, a new one every cycle.
      for (int i = 0; i < 150; i++) begin
         a = int'($urandom_range(511)) - 256;
         g = int'($urandom_range(511)) - 256;
         applyStimulus(a, g);
      end

      // Reset mid-cycle while running: output drops at once, pending results are void.
      #2;
      Rst = 1'b1;
      #1;
      checkOutput("midreset_def", int'($signed(res_def)), 0);
      checkOutput("midreset_hi", int'($signed(res_hi)), 0);
      sb.delete();
      resetModel();
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         checkOutput("reset_hold_def", int'($signed(res_def)), 0);
         checkOutput("reset_hold_hi", int'($signed(res_hi)), 0);
      end
      Rst = 1'b0;

      repeat (4) applyStimulus(100, 30);
      for (int i = 0; i < 60; i++) begin
         a = int'($urandom_range(511)) - 256;
         g = int'($urandom_range(511)) - 256;
         applyStimulus(a, g);
      end

      // Let the last queued results come out, with a bounded wait.
      drain = 0;
      while (sb.size() > 0 && drain < 10) begin
         @(negedge Clk);
         drain++;
      end
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: %0d results still pending, expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
